// File: rtl/sid_i2s_out.sv
// SID audio back end: box-car averages the 12-bit unsigned mix and streams it as
// signed 16-bit mono on both channels of a Philips I2S frame, with clocks derived from dot_clk.
module sid_i2s_out #(
    parameter int BCLK_DIV = 4,
    parameter int AVG_LOG2 = 5
) (
    input  logic        dot_clk,
    input  logic        reset,
    input  logic        audio_en,
    input  logic [11:0] audio,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        sample_strobe
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          r_lrclk;
    logic          r_sdata;
    logic          r_strobe;
    logic [4:0]    r_bit_cnt;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_hold;
    logic [31:0]   r_frame;

    logic          w_div_wrap;
    logic          w_fall;
    logic [4:0]    w_b;
    logic [4:0]    w_idx;
    logic          w_last;
    logic [AW-1:0] w_sum;
    logic [11:0]   w_avg;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_fall     = w_div_wrap && r_bclk;
    assign w_b        = r_bit_cnt + 5'd1;
    // Bit b of the frame period carries frame[32-b]; the 5-bit wrap makes b==0 pick the right LSB.
    assign w_idx      = 5'd0 - w_b;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_sum      = r_acc + AW'(audio);
    assign w_avg      = w_sum[AW-1 -: 12];

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_strobe  <= 1'b0;
            r_bit_cnt <= 5'd0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hold    <= 16'h0000;
            r_frame   <= 32'h0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end

            r_strobe <= 1'b0;
            if (audio_en) begin
                if (w_last) begin
                    // Flip the MSB to turn the midscale-offset average into two's complement.
                    r_hold   <= {~w_avg[11], w_avg[10:0], 4'b0000};
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_strobe <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            if (w_fall) begin
                r_bit_cnt <= w_b;
                r_lrclk   <= w_b[4];
                if (w_b == 5'd1) begin
                    r_frame <= {r_hold, r_hold};
                    r_sdata <= r_hold[15];
                end else begin
                    r_sdata <= r_frame[w_idx];
                end
            end
        end
    end

    assign i2s_bclk      = r_bclk;
    assign i2s_lrclk     = r_lrclk;
    assign i2s_sdata     = r_sdata;
    assign sample_strobe = r_strobe;
endmodule
